sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_bus_pkg.sv | 12 +
 rtl/rr_arb2.sv | 43 ++++
 rtl/sram_arbiter.sv | 103 ++++++++++
 tb/tb_sram_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared SRAM bus definitions: default port widths and master index type.
package sram_bus_pkg;

    localparam int unsigned LEN_ADDR_DEF = 64;
    localparam int unsigned LEN_DATA_DEF = 64;

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } mst_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: sole requester wins at once, contention goes
// to the master that was not granted most recently.
module rr_arb2
    import sram_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_c_o,
    output logic gnt1_c_o
);

    mst_idx_t last_q, last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= MST1;
        end else begin
            last_q <= last_d;
        end
    end

    // Grants are suppressed while reset is held; history moves only on a grant.
    always_comb begin
        gnt0_c_o = 1'b0;
        gnt1_c_o = 1'b0;
        last_d   = last_q;
        if (!rst) begin
            if (req0_i && (!req1_i || last_q == MST1)) begin
                gnt0_c_o = 1'b1;
            end else if (req1_i) begin
                gnt1_c_o = 1'b1;
            end
        end
        if (gnt0_c_o) begin
            last_d = MST0;
        end else if (gnt1_c_o) begin
            last_d = MST1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between two masters; read data is routed back to
// the requesting master with the SRAM's own one-cycle latency and then held.
module sram_arbiter
    import sram_bus_pkg::*;
#(
    parameter int unsigned LEN_ADDR = LEN_ADDR_DEF,
    parameter int unsigned LEN_DATA = LEN_DATA_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_ADDR-1:0]   m0_addra,
    input  logic [LEN_DATA-1:0]   m0_dina,
    input  logic                  m0_ena,
    input  logic [LEN_DATA/8-1:0] m0_wea,
    output logic                  m0_ready,
    output logic [LEN_DATA-1:0]   m0_douta,
    input  logic [LEN_ADDR-1:0]   m1_addra,
    input  logic [LEN_DATA-1:0]   m1_dina,
    input  logic                  m1_ena,
    input  logic [LEN_DATA/8-1:0] m1_wea,
    output logic                  m1_ready,
    output logic [LEN_DATA-1:0]   m1_douta,
    output logic [LEN_ADDR-1:0]   s_addra,
    output logic [LEN_DATA-1:0]   s_dina,
    output logic                  s_ena,
    output logic [LEN_DATA/8-1:0] s_wea,
    input  logic [LEN_DATA-1:0]   s_douta
);

    localparam int unsigned WE_W = LEN_DATA / 8;

    logic                gnt0, gnt1;
    logic                resp_valid_q, resp_valid_d;
    mst_idx_t            owner_q, owner_d;
    logic [LEN_DATA-1:0] hold0_q, hold0_d;
    logic [LEN_DATA-1:0] hold1_q, hold1_d;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req0_i   (m0_ena),
        .req1_i   (m1_ena),
        .gnt0_c_o (gnt0),
        .gnt1_c_o (gnt1)
    );

    // Request mux onto the shared SRAM port.
    always_comb begin
        m0_ready = gnt0;
        m1_ready = gnt1;
        s_ena    = 1'b0;
        s_wea    = WE_W'(0);
        s_addra  = m0_addra;
        s_dina   = m0_dina;
        if (gnt1) begin
            s_ena   = 1'b1;
            s_wea   = m1_wea;
            s_addra = m1_addra;
            s_dina  = m1_dina;
        end else if (gnt0) begin
            s_ena = 1'b1;
            s_wea = m0_wea;
        end
    end

    // Response tracking and per-master hold registers.
    always_comb begin
        resp_valid_d = s_ena && (s_wea == WE_W'(0));
        owner_d      = owner_q;
        if (gnt1) begin
            owner_d = MST1;
        end else if (gnt0) begin
            owner_d = MST0;
        end
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        if (resp_valid_q && owner_q == MST0) begin
            hold0_d = s_douta;
        end
        if (resp_valid_q && owner_q == MST1) begin
            hold1_d = s_douta;
        end
    end

    // The response cycle shows s_douta directly; hold_d equals it then.
    assign m0_douta = hold0_d;
    assign m1_douta = hold1_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            owner_q      <= MST0;
            hold0_q      <= LEN_DATA'(0);
            hold1_q      <= LEN_DATA'(0);
        end else begin
            resp_valid_q <= resp_valid_d;
            owner_q      <= owner_d;
            hold0_q      <= hold0_d;
            hold1_q      <= hold1_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_sram_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned WW = DW / 8;

    logic          clk, rst;
    logic [AW-1:0] m0_addra, m1_addra, s_addra;
    logic [DW-1:0] m0_dina, m1_dina, s_dina;
    logic          m0_ena, m1_ena, s_ena;
    logic [WW-1:0] m0_wea, m1_wea, s_wea;
    logic          m0_ready, m1_ready;
    logic [DW-1:0] m0_douta, m1_douta, s_douta;

    int tests = 0;
    int fails = 0;

    sram_arbiter #(.LEN_ADDR(AW), .LEN_DATA(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_addra(m0_addra), .m0_dina(m0_dina), .m0_ena(m0_ena), .m0_wea(m0_wea),
        .m0_ready(m0_ready), .m0_douta(m0_douta),
        .m1_addra(m1_addra), .m1_dina(m1_dina), .m1_ena(m1_ena), .m1_wea(m1_wea),
        .m1_ready(m1_ready), .m1_douta(m1_douta),
        .s_addra(s_addra), .s_dina(s_dina), .s_ena(s_ena), .s_wea(s_wea),
        .s_douta(s_douta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned idx(input logic [AW-1:0] a);
        return 32'(a[11:3]);
    endfunction

    function automatic logic [DW-1:0] init_word(input int unsigned i);
        if (i == 32'h20) return 64'hAA;
        if (i == 32'h40) return 64'h0;
        return {32'hC0DE_0000 | i, ~i};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] din,
                                            input logic [WW-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < int'(WW); b++)
            if (we[b]) r[8*b +: 8] = din[8*b +: 8];
        return r;
    endfunction

    // Behavioural SRAM with one-cycle read latency.
    logic [DW-1:0] sram_mem [0:511];
    bit            sram_wr  [0:511];
    logic [DW-1:0] sram_q;
    int unsigned   sidx;
    assign sidx    = idx(s_addra);
    assign s_douta = sram_q;

    function automatic logic [DW-1:0] sram_rd(input int unsigned i);
        return sram_wr[i] ? sram_mem[i] : init_word(i);
    endfunction

    always @(posedge clk) begin
        if (s_ena) begin
            if (s_wea != WW'(0)) begin
                sram_mem[sidx] <= merge(sram_rd(sidx), s_dina, s_wea);
                sram_wr[sidx]  <= 1'b1;
            end else begin
                sram_q <= sram_rd(sidx);
            end
        end
    end

    // Reference model state: memory image, round-robin preference, expected read-back.
    logic [DW-1:0] ref_mem [0:511];
    bit            ref_wr  [0:511];
    int            pref;
    logic [DW-1:0] exp_d0, exp_d1;

    function automatic logic [DW-1:0] ref_rd(input int unsigned i);
        return ref_wr[i] ? ref_mem[i] : init_word(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: check held read data, drive requests, check grant and SRAM port.
    task automatic step(input bit r0, input bit r1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                        output bit g0, output bit g1);
        bit            e0, e1;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [WW-1:0] w;
        @(negedge clk);
        chk("m0_douta", m0_douta, exp_d0);
        chk("m1_douta", m1_douta, exp_d1);
        m0_ena = r0; m0_addra = a0; m0_dina = d0; m0_wea = w0;
        m1_ena = r1; m1_addra = a1; m1_dina = d1; m1_wea = w1;
        #1;
        e0 = r0 && (!r1 || pref == 0);
        e1 = r1 && !e0;
        chk("m0_ready", 64'(m0_ready), 64'(e0));
        chk("m1_ready", 64'(m1_ready), 64'(e1));
        chk("s_ena", 64'(s_ena), 64'(e0 | e1));
        if (e0 || e1) begin
            a = e1 ? a1 : a0;
            d = e1 ? d1 : d0;
            w = e1 ? w1 : w0;
            chk("s_addra", s_addra, a);
            chk("s_wea", 64'(s_wea), 64'(w));
            if (w != WW'(0)) begin
                chk("s_dina", s_dina, d);
                ref_mem[idx(a)] = merge(ref_rd(idx(a)), d, w);
                ref_wr[idx(a)]  = 1'b1;
            end else if (e1) begin
                exp_d1 = ref_rd(idx(a));
            end else begin
                exp_d0 = ref_rd(idx(a));
            end
            pref = e0 ? 1 : 0;
        end else begin
            chk("s_wea_idle", 64'(s_wea), 64'h0);
        end
        g0 = m0_ready;
        g1 = m1_ready;
    endtask

    task automatic idle();
        bit g0, g1;
        step(0, 0, '0, '0, '0, '0, '0, '0, g0, g1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        m0_ena = 1'b1; m0_wea = '0; m1_ena = 1'b1; m1_wea = '1;
        #1;
        chk("rst_m0_ready", 64'(m0_ready), 64'h0);
        chk("rst_m1_ready", 64'(m1_ready), 64'h0);
        chk("rst_s_ena", 64'(s_ena), 64'h0);
        chk("rst_s_wea", 64'(s_wea), 64'h0);
        chk("rst_m0_douta", m0_douta, 64'h0);
        chk("rst_m1_douta", m1_douta, 64'h0);
        pref = 0; exp_d0 = '0; exp_d1 = '0;
        @(negedge clk);
        rst = 1'b0;
        m0_ena = 1'b0; m1_ena = 1'b0; m0_wea = '0; m1_wea = '0;
    endtask

    initial begin
        bit            g0, g1;
        bit            p0, p1;
        logic [AW-1:0] pa0, pa1;
        logic [DW-1:0] pd0, pd1;
        logic [WW-1:0] pw0, pw1;
        logic [AW-1:0] pool [5];

        rst = 1'b1;
        m0_ena = 0; m1_ena = 0; m0_addra = '0; m1_addra = '0;
        m0_dina = '0; m1_dina = '0; m0_wea = '0; m1_wea = '0;
        pref = 0; exp_d0 = '0; exp_d1 = '0;
        pool[0] = 64'h100; pool[1] = 64'h108; pool[2] = 64'h200;
        pool[3] = 64'h208; pool[4] = 64'h300;
        apply_reset();

        // Sole reader m0 at 0x100.
        step(1, 0, 64'h100, '0, '0, '0, '0, '0, g0, g1);
        chk("solo_ready", 64'(g0), 64'h1);
        idle();
        chk("solo_douta", m0_douta, 64'hAA);
        idle();
        chk("solo_hold", m0_douta, 64'hAA);

        // First contention after reset goes to m0, m1 next cycle.
        apply_reset();
        step(1, 1, 64'h100, 64'h108, '0, '0, '0, '0, g0, g1);
        chk("cont_first_m0", 64'(g0), 64'h1);
        step(0, 1, '0, 64'h108, '0, '0, '0, '0, g0, g1);
        chk("cont_second_m1", 64'(g1), 64'h1);
        chk("cont_m0_douta", m0_douta, 64'hAA);
        idle();

        // Continuous contention alternates every cycle.
        for (int i = 0; i < 6; i++) begin
            step(1, 1, pool[i % 5], pool[(i + 2) % 5], '0, '0, '0, '0, g0, g1);
            chk("alt_m0", 64'(g0), 64'((i % 2) == 0));
            chk("alt_m1", 64'(g1), 64'((i % 2) == 1));
        end
        idle();

        // m1 writes 0x55 to 0x200, m0 reads it back.
        step(0, 1, '0, 64'h200, '0, 64'h55, '0, 8'hFF, g0, g1);
        step(1, 0, 64'h200, '0, '0, '0, '0, '0, g0, g1);
        idle();
        chk("wr_rd_m0", m0_douta, 64'h55);
        chk("wr_rd_m1_kept", m1_douta, exp_d1);

        // Reset while m1's read response is outstanding.
        step(0, 1, '0, 64'h100, '0, '0, '0, '0, g0, g1);
        @(negedge clk);
        rst = 1'b1;
        m1_ena = 1'b0;
        #1;
        chk("rstmid_s_ena", 64'(s_ena), 64'h0);
        chk("rstmid_m1_douta", m1_douta, 64'h0);
        pref = 0; exp_d0 = '0; exp_d1 = '0;
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 64'h108, 64'h208, '0, '0, '0, '0, g0, g1);
        chk("rstmid_m0_wins", 64'(g0), 64'h1);
        idle();

        // Randomized traffic; an ungranted master holds its request.
        p0 = 0; p1 = 0;
        pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0; pw0 = '0; pw1 = '0;
        for (int c = 0; c < 300; c++) begin
            if (!p0) begin
                p0  = ($urandom_range(0, 9) < 7);
                pa0 = pool[$urandom_range(0, 4)];
                pd0 = {$urandom, $urandom};
                pw0 = $urandom_range(0, 1) ? WW'($urandom) : WW'(0);
            end
            if (!p1) begin
                p1  = ($urandom_range(0, 9) < 7);
                pa1 = pool[$urandom_range(0, 4)];
                pd1 = {$urandom, $urandom};
                pw1 = $urandom_range(0, 1) ? WW'($urandom) : WW'(0);
            end
            step(p0, p1, pa0, pa1, pd0, pd1, pw0, pw1, g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
